// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes one BCD-to-7-segment decoder across NUM_DIGITS common-anode digits with dead time between slots; optional LEADING_ZERO_BLANK_EN blanks leading zeros
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DEAD_CYC   = 2,
  parameter int ON_CYC     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    disp_en,
  output logic [3:0]              dec_bcd,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);
  localparam logic [0:0] DEAD  = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [0:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending, display;
  logic                    dead_end, drive_end, wrap, blank;
  logic [3:0]              cur;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  run;
  // lz[k] is set when digit k and every digit above it are zero; digit 0 is never blanked
  always_comb begin
    lz = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS-1; k > 0; k--) begin
      run = run && (display[4*k +: 4] == 4'd0);
      lz[k] = run;
    end
  end
`endif

  // Slot timing decode and blanking of the digit currently being driven
  always_comb begin
    dead_end  = (state == DEAD)  && (cnt == CNT_W'(DEAD_CYC-1));
    drive_end = (state == DRIVE) && (cnt == CNT_W'(ON_CYC-1));
    wrap      = drive_end && (idx == IW'(NUM_DIGITS-1));
    cur       = display[4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank     = (dec_bcd > 4'd9) || lz[idx];
`else
    blank     = dec_bcd > 4'd9;
`endif
  end

  // Scan FSM, frame-synchronous display update and registered pin outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= DEAD;
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      display    <= '0;
      dec_bcd    <= 4'd0;
      seg_out    <= 7'h7F;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (state == DEAD) begin
        dec_bcd <= cur;
        cnt     <= dead_end ? '0 : cnt + CNT_W'(1);
        state   <= dead_end ? DRIVE : DEAD;
      end else begin
        cnt   <= drive_end ? '0 : cnt + CNT_W'(1);
        state <= drive_end ? DEAD : DRIVE;
        idx   <= drive_end ? (wrap ? '0 : idx + IW'(1)) : idx;
      end
      pending <= load ? digits_in : pending;
      display <= wrap ? (load ? digits_in : pending) : display;
      an_out  <= (state == DRIVE && disp_en) ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg_out <= (state == DRIVE && disp_en && !blank) ? seg_in : 7'h7F;
    end
  end
endmodule
